conversor_bcd_velocidad: RTL and testbench

//   Sequential binary-to-BCD converter feeding the LCD digit encoder stage.

---
 rtl/velocimetro_pkg.sv | 7 +
 rtl/ajuste_bcd_digito.sv | 7 +
 rtl/conversor_bcd_velocidad.sv | 71 +++++++
 tb/tb_conversor_bcd_velocidad.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/velocimetro_pkg.sv
// velocimetro_pkg: shared constants and state encoding for the speed BCD converter
package velocimetro_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} estado_t;
    localparam int BCD_MAX = 9999;
    localparam int DIGIT_W = 4;
    localparam int FRAC_W  = 4;
endpackage

// File: rtl/ajuste_bcd_digito.sv
// ajuste_bcd_digito: add-3 correction for one BCD nibble before a double-dabble shift
module ajuste_bcd_digito (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/conversor_bcd_velocidad.sv
// conversor_bcd_velocidad: serial double-dabble conversion of fixed-point speed to four BCD digits
module conversor_bcd_velocidad
    import velocimetro_pkg::*;
#(
    parameter int INT_W = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [INT_W+FRAC_W-1:0]   valor,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [DIGIT_W-1:0]        miles,
    output logic [DIGIT_W-1:0]        centenas,
    output logic [DIGIT_W-1:0]        decenas,
    output logic [DIGIT_W-1:0]        unidades,
    output logic [FRAC_W-1:0]         decimal
);
    estado_t state, nxt;
    logic [16+INT_W-1:0] sr;
    logic [INT_W-1:0] int_val;
    logic [15:0] bcd, adj;
    logic [FRAC_W-1:0] frac;
    logic [4:0] count;
    logic ovf_pend, ovf_in;
    assign int_val = valor[INT_W+FRAC_W-1:FRAC_W];
    assign ovf_in = 17'(int_val) > 17'(BCD_MAX);
    assign bcd = sr[16+INT_W-1:INT_W];
    for (genvar i = 0; i < 4; i++) begin : g_aj
        ajuste_bcd_digito u_aj (.d(bcd[4*i+:4]), .q(adj[4*i+:4]));
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state == IDLE ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (count == 5'd0 ? DONE : SHIFT) : IDLE;
        busy = state != IDLE;
        done = state == DONE;
    end
    // Integers above 9999 are clamped so the accumulator never needs a fifth digit
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            frac <= '0;
            count <= '0;
            ovf_pend <= 1'b0;
            overflow <= 1'b0;
            miles <= '0;
            centenas <= '0;
            decenas <= '0;
            unidades <= '0;
            decimal <= '0;
        end else if (state == IDLE && start) begin
            sr <= {16'd0, ovf_in ? INT_W'(BCD_MAX) : int_val};
            frac <= valor[FRAC_W-1:0];
            count <= 5'(INT_W);
            ovf_pend <= ovf_in;
        end else if (state == SHIFT && count != 5'd0) begin
            sr <= {adj, sr[INT_W-1:0]} << 1;
            count <= count - 5'd1;
        end else if (state == SHIFT) begin
            miles <= ovf_pend ? 4'd9 : bcd[15:12];
            centenas <= ovf_pend ? 4'd9 : bcd[11:8];
            decenas <= ovf_pend ? 4'd9 : bcd[7:4];
            unidades <= ovf_pend ? 4'd9 : bcd[3:0];
            overflow <= ovf_pend;
            decimal <= frac;
        end
    end
endmodule

// File: tb/tb_conversor_bcd_velocidad.sv
// tb_conversor_bcd_velocidad: vector table, handshake corner cases and random sweep against a decimal model
module tb_conversor_bcd_velocidad;
    logic clk = 1'b0;
    logic rst, start, busy, done, overflow;
    logic [17:0] valor;
    logic [3:0] miles, centenas, decenas, unidades, decimal;
    logic [20:0] out;
    int n_cmp = 0;
    int n_bad = 0;

    conversor_bcd_velocidad dut (
        .clk(clk), .rst(rst), .start(start), .valor(valor),
        .busy(busy), .done(done), .overflow(overflow),
        .miles(miles), .centenas(centenas), .decenas(decenas),
        .unidades(unidades), .decimal(decimal)
    );

    always #5 clk = ~clk;
    assign out = {overflow, miles, centenas, decenas, unidades, decimal};

    typedef struct {
        logic [17:0] v;
        logic [20:0] exp;
    } vec_t;
    vec_t vecs[10];
    logic [17:0] vals[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal model: {overflow, thousands, hundreds, tens, units, fraction}
    function automatic logic [20:0] ref_out(input logic [17:0] v);
        int n;
        n = int'(v[17:4]);
        if (n > 9999) return {1'b1, 16'h9999, v[3:0]};
        return {1'b0, 4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10), v[3:0]};
    endfunction

    task automatic run(input logic [17:0] v, output int lat);
        @(negedge clk);
        valor = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valor = 18'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pulse_end(input string name);
        @(posedge clk);
        #1;
        chk(name, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int lat, dones, done_at, idle_cnt, idle_at, k;
        logic [20:0] got1;
        rst = 1'b1;
        start = 1'b0;
        valor = '0;
        vecs[0] = '{{14'd1234, 4'd8}, {1'b0, 16'h1234, 4'h8}};
        vecs[1] = '{{14'd0, 4'd0}, {1'b0, 16'h0000, 4'h0}};
        vecs[2] = '{{14'd9999, 4'hF}, {1'b0, 16'h9999, 4'hF}};
        vecs[3] = '{{14'd12000, 4'd3}, {1'b1, 16'h9999, 4'h3}};
        vecs[4] = '{{14'd42, 4'd0}, {1'b0, 16'h0042, 4'h0}};
        vecs[5] = '{{14'd16383, 4'hF}, {1'b1, 16'h9999, 4'hF}};
        vecs[6] = '{{14'd10000, 4'd1}, {1'b1, 16'h9999, 4'h1}};
        vecs[7] = '{{14'd9, 4'd9}, {1'b0, 16'h0009, 4'h9}};
        vecs[8] = '{{14'd5000, 4'd7}, {1'b0, 16'h5000, 4'h7}};
        vecs[9] = '{{14'd8765, 4'd4}, {1'b0, 16'h8765, 4'h4}};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {11'd0, out}, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].v, lat);
            chk($sformatf("vec%0d_latency", i), lat, 15);
            chk($sformatf("vec%0d_out", i), {11'd0, out}, {11'd0, vecs[i].exp});
            pulse_end($sformatf("vec%0d_pulse", i));
        end

        // start held high while valor changes every cycle
        foreach (vals[i]) vals[i] = 18'($urandom);
        dones = 0; done_at = -1; idle_cnt = 0; idle_at = -1; got1 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valor = vals[i];
            start = 1'b1;
            @(posedge clk);
            #1;
            if (done) begin dones++; done_at = i; got1 = out; end
            if (!busy) begin idle_cnt++; idle_at = i; end
        end
        start = 1'b0;
        chk("held_done_count", dones, 1);
        chk("held_done_at", done_at, 15);
        chk("held_first_out", {11'd0, got1}, {11'd0, ref_out(vals[0])});
        chk("held_idle_count", idle_cnt, 1);
        chk("held_idle_at", idle_at, 16);
        k = 19;
        while (!done && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("held_second_done_at", k, 32);
        chk("held_second_out", {11'd0, out}, {11'd0, ref_out(vals[17])});
        pulse_end("held_second_pulse");

        // reset in the middle of a conversion
        run({14'd1234, 4'd8}, lat);
        pulse_end("prerst_pulse");
        @(negedge clk);
        valor = {14'd777, 4'd5};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst_out", {11'd0, out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run({14'd777, 4'd5}, lat);
        chk("postrst_latency", lat, 15);
        chk("postrst_out", {11'd0, out}, {11'd0, 1'b0, 16'h0777, 4'h5});
        pulse_end("postrst_pulse");

        // random sweep
        for (int i = 0; i < 2000; i++) begin
            logic [17:0] v;
            v = 18'($urandom);
            run(v, lat);
            chk("rnd_latency", lat, 15);
            chk("rnd_out", {11'd0, out}, {11'd0, ref_out(v)});
            pulse_end("rnd_pulse");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
